// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared across the CPU front end.
//   XLEN          - architectural register / PC width.
//   cnt_e         - 2-bit saturating branch counter encodings.
//   sat_cnt_next  - next value of a 2-bit saturating counter given an outcome.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  // Counts up on taken and down on not-taken, sticking at ST and SNT.
  function automatic logic [1:0] sat_cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_table.sv
// btb_table: direct-mapped branch target buffer storage.
//   clk, rst_n         - clock (rising edge) and async active-low reset.
//   rd_idx             - IF lookup index (async read).
//   rd_valid/tag/target/cnt - contents of entry rd_idx, pre-edge value.
//   upd_en             - resolve a conditional branch this cycle.
//   upd_idx/tag        - index and tag of the resolving branch.
//   upd_taken          - actual outcome of the resolving branch.
//   upd_target         - resolved target of the branch.
// The hit check for the update is done here, against the stored tag at upd_idx.
module btb_table
  import cpu_pkg::*;
#(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = XLEN - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [XLEN-1:0]  rd_target,
  output logic [1:0]       rd_cnt,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target
);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       cnt_q    [ENTRIES];

  logic upd_hit;

  // No bypass: a same-cycle update is only visible to IF after the edge.
  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign rd_cnt    = cnt_q[rd_idx];

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // A hit trains the counter (and refreshes the target when taken);
  // a taken miss replaces the entry as weakly-taken; a not-taken miss is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= WNT;
      end
    end else if (upd_en) begin
      if (upd_hit) begin
        cnt_q[upd_idx] <= sat_cnt_next(cnt_q[upd_idx], upd_taken);
        if (upd_taken) target_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        cnt_q[upd_idx]    <= WT;
      end
    end
  end

endmodule

// File: rtl/npc_btb_predictor.sv
// npc_btb_predictor: IF-stage next-PC generator with a direct-mapped BTB.
//   CPU_CLK, CPU_RST_N   - clock and async active-low reset.
//   PCF                  - current fetch PC; PC_In is the next PC.
//   JalD/JalTarget       - jal redirect from ID.
//   JalrE/JalrTarget     - jalr redirect from EX.
//   BrInstE/BranchE/BranchTarget/PCE/PredTakenE - conditional branch in EX.
//   StallF, StallE       - stalls; StallE freezes BTB training and counters.
//   PredTakenF           - IF prediction for PCF.
//   MispredictE          - EX branch outcome disagrees with its prediction.
//   BrCount, MissCount   - resolved branches and mispredicts (wrap around).
// PRED_EN=0 forces every lookup to miss, giving static predict-not-taken.
module npc_btb_predictor
  import cpu_pkg::*;
#(
  parameter  int ENTRIES = 64,
  parameter  int PRED_EN = 1,
  parameter  int CNT_W   = 32,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RST_N,
  input  logic [XLEN-1:0]  PCF,
  input  logic             StallF,
  input  logic             JalD,
  input  logic [XLEN-1:0]  JalTarget,
  input  logic             JalrE,
  input  logic [XLEN-1:0]  JalrTarget,
  input  logic             BrInstE,
  input  logic             BranchE,
  input  logic [XLEN-1:0]  BranchTarget,
  input  logic [XLEN-1:0]  PCE,
  input  logic             PredTakenE,
  input  logic             StallE,
  output logic [XLEN-1:0]  PC_In,
  output logic             PredTakenF,
  output logic             MispredictE,
  output logic [CNT_W-1:0] BrCount,
  output logic [CNT_W-1:0] MissCount
);

  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [XLEN-1:0]  rd_target;
  logic [1:0]       rd_cnt;
  logic             hit_f;
  logic             upd_en;

  // PC low bits are always zero for aligned fetch; StallF only documents hold.
  logic unused_bits;
  assign unused_bits = ^{PCF[1:0], PCE[1:0], StallF};

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[XLEN-1:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[XLEN-1:IDX_W+2];

  assign upd_en = BrInstE & ~StallE;

  btb_table #(.ENTRIES(ENTRIES)) u_btb (
    .clk        (CPU_CLK),
    .rst_n      (CPU_RST_N),
    .rd_idx     (idx_f),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_target  (rd_target),
    .rd_cnt     (rd_cnt),
    .upd_en     (upd_en),
    .upd_idx    (idx_e),
    .upd_tag    (tag_e),
    .upd_taken  (BranchE),
    .upd_target (BranchTarget)
  );

  assign hit_f       = (PRED_EN != 0) && rd_valid && (rd_tag == tag_f);
  assign PredTakenF  = hit_f & rd_cnt[1];
  assign MispredictE = BrInstE & (BranchE ^ PredTakenE);

  // Older instructions win: EX mispredict, then EX jalr, then ID jal, then the IF guess.
  always_comb begin
    PC_In = PCF + 32'd4;
    if (MispredictE && BranchE)       PC_In = BranchTarget;
    else if (MispredictE && !BranchE) PC_In = PCE + 32'd4;
    else if (JalrE)                   PC_In = JalrTarget;
    else if (JalD)                    PC_In = JalTarget;
    else if (PredTakenF)              PC_In = rd_target;
  end

  // Performance counters share the BTB training enable.
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      BrCount   <= '0;
      MissCount <= '0;
    end else if (upd_en) begin
      BrCount   <= BrCount + CNT_W'(1);
      MissCount <= MissCount + CNT_W'(MispredictE);
    end
  end

endmodule
